// File: rtl/siso_pkg.sv
// Shared definitions for the max-log-MAP SISO stages (alpha_branch and beta_llr).
package siso_pkg;

  typedef enum logic [1:0] {IDLE, START, RUN, FLUSH} state_e;

  localparam logic signed [15:0] ALPHA_INIT = -16'sd128;
  localparam int unsigned TAIL_LEN = 4;

  function automatic logic signed [15:0] sat16(input logic signed [17:0] x);
    if (x > 18'sd32767) return 16'sh7fff;
    if (x < -18'sd32768) return 16'sh8000;
    return x[15:0];
  endfunction

  function automatic logic signed [17:0] sext18(input logic [15:0] v);
    return {{2{v[15]}}, v};
  endfunction

endpackage

// File: rtl/acs_max2.sv
// Compare-select of two signed 18-bit path metrics; returns the larger.
module acs_max2 (
  input  logic [17:0] a_i,
  input  logic [17:0] b_i,
  output logic [17:0] max_o
);

  assign max_o = ($signed(a_i) > $signed(b_i)) ? a_i : b_i;

endmodule

// File: rtl/alpha_branch.sv
// Forward (alpha) stage of the max-log-MAP SISO decoder: branch metrics, 8-state ACS
// recursion and step stream formatted for beta_llr.
module alpha_branch
  import siso_pkg::*;
#(
  parameter int unsigned blklen_w = 6144
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_blklen,
  input  logic [15:0] blklen,
  input  logic [1:0]  beta_state,
  input  logic        valid_in,
  input  logic [15:0] sys,
  input  logic [15:0] parity,
  input  logic [15:0] apriori,
  output logic        in_ready,
  output logic        valid_blklen_out,
  output logic [15:0] blklen_out,
  output logic        valid_branch,
  output logic [15:0] init_branch1,
  output logic [15:0] init_branch2,
  output logic [15:0] alpha_0,
  output logic [15:0] alpha_1,
  output logic [15:0] alpha_2,
  output logic [15:0] alpha_3,
  output logic [15:0] alpha_4,
  output logic [15:0] alpha_5,
  output logic [15:0] alpha_6,
  output logic [15:0] alpha_7,
  output logic        valid_sys,
  output logic        valid_apriori,
  output logic [15:0] sys_out,
  output logic [15:0] apriori_out,
  output logic        blk_err
);

  localparam int unsigned KW = $clog2(blklen_w + TAIL_LEN + 1);

  state_e state_q, state_d;
  logic [KW-1:0]      k_q;
  logic [15:0]        blklen_q;
  logic               valid_branch_q, blk_err_q;
  logic signed [15:0] b1_q, b2_q, sys_q, apr_q;
  logic signed [15:0] alpha_q [8];
  logic signed [15:0] alpha_d [8];
  logic signed [17:0] cand_p [8];
  logic signed [17:0] cand_m [8];
  logic signed [17:0] n [8];

  logic               start_ok, blk_legal, accept, last_step, tail;
  logic [15:0]        apr_eff;
  logic signed [17:0] sum_base, sum1, sum2;

  assign blk_legal = (blklen != '0) && (32'(blklen) <= blklen_w);
  assign start_ok  = (state_q == IDLE) && valid_blklen && (beta_state == 2'd0);
  assign accept    = (state_q == RUN) && valid_in;
  assign last_step = (32'(k_q) == 32'(blklen_q) + TAIL_LEN - 1);
  // Tail steps carry no a-priori information.
  assign tail      = (32'(k_q) >= 32'(blklen_q));
  assign apr_eff   = tail ? '0 : apriori;

  assign sum_base = sext18(sys) + sext18(apr_eff);
  assign sum1     = sum_base + sext18(parity);
  assign sum2     = sum_base - sext18(parity);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok && blk_legal) state_d = START;
      START:   state_d = RUN;
      RUN:     if (accept && last_step) state_d = FLUSH;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready         = (state_q == RUN);
    valid_blklen_out = (state_q == START);
  end

  // Trellis: each state picks between a +gamma and a -gamma predecessor.
  always_comb begin
    cand_p[0] = sext18(alpha_q[0]) + sext18(b1_q);
    cand_m[0] = sext18(alpha_q[1]) - sext18(b1_q);
    cand_p[1] = sext18(alpha_q[3]) + sext18(b2_q);
    cand_m[1] = sext18(alpha_q[2]) - sext18(b2_q);
    cand_p[2] = sext18(alpha_q[4]) + sext18(b2_q);
    cand_m[2] = sext18(alpha_q[5]) - sext18(b2_q);
    cand_p[3] = sext18(alpha_q[7]) + sext18(b1_q);
    cand_m[3] = sext18(alpha_q[6]) - sext18(b1_q);
    cand_p[4] = sext18(alpha_q[1]) + sext18(b1_q);
    cand_m[4] = sext18(alpha_q[0]) - sext18(b1_q);
    cand_p[5] = sext18(alpha_q[2]) + sext18(b2_q);
    cand_m[5] = sext18(alpha_q[3]) - sext18(b2_q);
    cand_p[6] = sext18(alpha_q[5]) + sext18(b2_q);
    cand_m[6] = sext18(alpha_q[4]) - sext18(b2_q);
    cand_p[7] = sext18(alpha_q[6]) + sext18(b1_q);
    cand_m[7] = sext18(alpha_q[7]) - sext18(b1_q);
  end

  for (genvar j = 0; j < 8; j++) begin : g_acs
    acs_max2 u_acs (
      .a_i  (cand_p[j]),
      .b_i  (cand_m[j]),
      .max_o(n[j])
    );
    assign alpha_d[j] = sat16(n[j] - n[0]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      k_q            <= '0;
      blklen_q       <= '0;
      valid_branch_q <= 1'b0;
      blk_err_q      <= 1'b0;
      b1_q           <= '0;
      b2_q           <= '0;
      sys_q          <= '0;
      apr_q          <= '0;
      for (int j = 0; j < 8; j++) alpha_q[j] <= (j == 0) ? 16'sd0 : ALPHA_INIT;
    end else begin
      state_q        <= state_d;
      blk_err_q      <= start_ok && !blk_legal;
      valid_branch_q <= accept;
      if (start_ok && blk_legal) blklen_q <= blklen;
      if (state_q == START) k_q <= '0;
      else if (accept) k_q <= k_q + 1'b1;
      if (accept) begin
        b1_q  <= sat16(sum1 >>> 1);
        b2_q  <= sat16(sum2 >>> 1);
        sys_q <= sys;
        apr_q <= apr_eff;
      end
      if (state_q == START) begin
        for (int j = 0; j < 8; j++) alpha_q[j] <= (j == 0) ? 16'sd0 : ALPHA_INIT;
      end else if (valid_branch_q) begin
        for (int j = 0; j < 8; j++) alpha_q[j] <= alpha_d[j];
      end
    end
  end

  assign blklen_out    = blklen_q;
  assign valid_branch  = valid_branch_q;
  assign valid_sys     = valid_branch_q;
  assign valid_apriori = valid_branch_q;
  assign init_branch1  = b1_q;
  assign init_branch2  = b2_q;
  assign sys_out       = sys_q;
  assign apriori_out   = apr_q;
  assign blk_err       = blk_err_q;
  assign alpha_0       = alpha_q[0];
  assign alpha_1       = alpha_q[1];
  assign alpha_2       = alpha_q[2];
  assign alpha_3       = alpha_q[3];
  assign alpha_4       = alpha_q[4];
  assign alpha_5       = alpha_q[5];
  assign alpha_6       = alpha_q[6];
  assign alpha_7       = alpha_q[7];

endmodule
